// File: rtl/dx_decode_latch_if.sv
// rtl/dx_decode_latch_if.sv - decode/execute pipeline register bus bundle
interface dx_decode_latch_if;
    logic [31:0] pc_in;
    logic [31:0] insn_in;
    logic        valid_in;
    logic        stall;
    logic        flush;

    logic [31:0] pc_out;
    logic [31:0] insn_out;
    logic        valid_out;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [16:0] imm17;
    logic [26:0] target;
    logic        is_rtype;
    logic        is_itype;
    logic        is_branch;
    logic        is_jump;
    logic        is_mem;

    modport master (
        output pc_in, insn_in, valid_in, stall, flush,
        input  pc_out, insn_out, valid_out, opcode, rd, rs, rt, shamt, aluop,
               imm17, target, is_rtype, is_itype, is_branch, is_jump, is_mem
    );

    modport slave (
        input  pc_in, insn_in, valid_in, stall, flush,
        output pc_out, insn_out, valid_out, opcode, rd, rs, rt, shamt, aluop,
               imm17, target, is_rtype, is_itype, is_branch, is_jump, is_mem
    );
endinterface

// File: rtl/dx_decode_latch.sv
// rtl/dx_decode_latch.sv - decode/execute pipeline register with field split,
// class flags, stall hold and bubble insertion
module dx_decode_latch (
    input  logic              clock,
    input  logic              reset,
    dx_decode_latch_if.slave  bus
);
    logic [4:0] op_in;
    logic       rtype_d;
    logic       itype_d;
    logic       branch_d;
    logic       jump_d;
    logic       mem_d;
    logic       bubble;

    assign op_in = bus.insn_in[31:27];
    // A load of a non-valid instruction is indistinguishable from a flush
    assign bubble = bus.flush || (!bus.stall && !bus.valid_in);

    always_comb begin
        rtype_d  = 1'b0;
        itype_d  = 1'b0;
        branch_d = 1'b0;
        jump_d   = 1'b0;
        mem_d    = 1'b0;
        case (op_in)
            5'b00000: rtype_d = 1'b1;
            5'b00101: itype_d = 1'b1;
            5'b00111, 5'b01000: begin
                itype_d = 1'b1;
                mem_d   = 1'b1;
            end
            5'b00010, 5'b00110: begin
                itype_d  = 1'b1;
                branch_d = 1'b1;
            end
            5'b00001, 5'b00011, 5'b00100, 5'b10110: jump_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.pc_out    <= 32'h0;
            bus.insn_out  <= 32'h0;
            bus.valid_out <= 1'b0;
            bus.opcode    <= 5'h0;
            bus.rd        <= 5'h0;
            bus.rs        <= 5'h0;
            bus.rt        <= 5'h0;
            bus.shamt     <= 5'h0;
            bus.aluop     <= 5'h0;
            bus.imm17     <= 17'h0;
            bus.target    <= 27'h0;
            bus.is_rtype  <= 1'b0;
            bus.is_itype  <= 1'b0;
            bus.is_branch <= 1'b0;
            bus.is_jump   <= 1'b0;
            bus.is_mem    <= 1'b0;
        end else if (bubble) begin
            bus.pc_out    <= bus.pc_in;
            bus.insn_out  <= 32'h0;
            bus.valid_out <= 1'b0;
            bus.opcode    <= 5'h0;
            bus.rd        <= 5'h0;
            bus.rs        <= 5'h0;
            bus.rt        <= 5'h0;
            bus.shamt     <= 5'h0;
            bus.aluop     <= 5'h0;
            bus.imm17     <= 17'h0;
            bus.target    <= 27'h0;
            bus.is_rtype  <= 1'b0;
            bus.is_itype  <= 1'b0;
            bus.is_branch <= 1'b0;
            bus.is_jump   <= 1'b0;
            bus.is_mem    <= 1'b0;
        end else if (!bus.stall) begin
            bus.pc_out    <= bus.pc_in;
            bus.insn_out  <= bus.insn_in;
            bus.valid_out <= 1'b1;
            bus.opcode    <= bus.insn_in[31:27];
            bus.rd        <= bus.insn_in[26:22];
            bus.rs        <= bus.insn_in[21:17];
            bus.rt        <= bus.insn_in[16:12];
            bus.shamt     <= bus.insn_in[11:7];
            bus.aluop     <= bus.insn_in[6:2];
            bus.imm17     <= bus.insn_in[16:0];
            bus.target    <= bus.insn_in[26:0];
            bus.is_rtype  <= rtype_d;
            bus.is_itype  <= itype_d;
            bus.is_branch <= branch_d;
            bus.is_jump   <= jump_d;
            bus.is_mem    <= mem_d;
        end
    end
endmodule

// File: tb/tb_dx_decode_latch.sv
// tb/tb_dx_decode_latch.sv - directed and randomized checks of dx_decode_latch
module tb_dx_decode_latch;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] m_pc;
    logic [31:0] m_insn;
    logic        m_valid;

    dx_decode_latch_if bus ();

    dx_decode_latch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_list(input int v, input int lst[$]);
        foreach (lst[i]) if (lst[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        int op;
        int ins;
        ins = int'(m_insn);
        op  = (ins >>> 27) & 31;
        check({tag, ".pc"},     bus.pc_out,    m_pc);
        check({tag, ".insn"},   bus.insn_out,  m_insn);
        check({tag, ".valid"},  bus.valid_out, m_valid);
        check({tag, ".opcode"}, bus.opcode,    op);
        check({tag, ".rd"},     bus.rd,        (ins >>> 22) & 31);
        check({tag, ".rs"},     bus.rs,        (ins >>> 17) & 31);
        check({tag, ".rt"},     bus.rt,        (ins >>> 12) & 31);
        check({tag, ".shamt"},  bus.shamt,     (ins >>> 7) & 31);
        check({tag, ".aluop"},  bus.aluop,     (ins >>> 2) & 31);
        check({tag, ".imm17"},  bus.imm17,     ins & 32'h1FFFF);
        check({tag, ".target"}, bus.target,    ins & 32'h7FFFFFF);
        check({tag, ".rtype"},  bus.is_rtype,  m_valid && op == 0);
        check({tag, ".itype"},  bus.is_itype,  m_valid && in_list(op, '{5, 7, 8, 2, 6}));
        check({tag, ".branch"}, bus.is_branch, m_valid && in_list(op, '{2, 6}));
        check({tag, ".jump"},   bus.is_jump,   m_valid && in_list(op, '{1, 3, 4, 22}));
        check({tag, ".mem"},    bus.is_mem,    m_valid && in_list(op, '{7, 8}));
    endtask

    // Applies one clock edge with the given inputs and advances the reference
    task automatic step(input string tag, input bit r, input bit f, input bit s,
                        input bit v, input logic [31:0] pc, input logic [31:0] insn);
        reset        = r;
        bus.flush    = f;
        bus.stall    = s;
        bus.valid_in = v;
        bus.pc_in    = pc;
        bus.insn_in  = insn;
        @(posedge clock);
        #1;
        if (r) begin
            m_pc = 0; m_insn = 0; m_valid = 0;
        end else if (f || (!s && !v)) begin
            m_pc = pc; m_insn = 0; m_valid = 0;
        end else if (!s) begin
            m_pc = pc; m_insn = insn; m_valid = 1;
        end
        compare_all(tag);
    endtask

    initial begin
        int ops[$] = '{0, 5, 7, 8, 2, 6, 1, 3, 4, 22, 21};
        logic [31:0] ins;
        logic [31:0] sext;
        checks = 0;
        errors = 0;
        m_pc = 0; m_insn = 0; m_valid = 0;

        step("rst0", 1, 0, 0, 1, 32'd4, 32'h2884_0005);
        step("rst1", 1, 0, 0, 1, 32'd4, 32'h2884_0005);
        step("addi", 0, 0, 0, 1, 32'd4, 32'h2884_0005);
        check("addi.opcode_lit", bus.opcode, 5'b00101);
        check("addi.rd_lit", bus.rd, 2);
        check("addi.imm_lit", bus.imm17, 17'h00005);

        step("lw", 0, 0, 0, 1, 32'd8, 32'h4100_0000 | 32'h1FFFC);
        sext = {{15{bus.imm17[16]}}, bus.imm17};
        check("lw.sext", sext, 32'hFFFF_FFFC);
        check("lw.mem_lit", bus.is_mem, 1);

        step("add", 0, 0, 0, 1, 32'd12, 32'h0084_3000);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 1, 1, 32'd16 + i, $urandom);
        step("unstall", 0, 0, 0, 1, 32'd40, 32'h1880_0004);

        step("stflush", 0, 1, 1, 1, 32'd44, 32'h3884_0008);
        check("stflush.pc_lit", bus.pc_out, 32'd44);
        step("novalid", 0, 0, 0, 0, 32'd48, 32'h2884_0005);

        step("jal", 0, 0, 0, 1, 32'd52, 32'h1800_0100);
        step("jalhold", 0, 0, 1, 1, 32'd56, 32'h2884_0005);
        step("rststall", 1, 0, 1, 1, 32'd60, 32'h2884_0005);
        step("postrst", 0, 0, 0, 1, 32'd64, 32'h4100_0010);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0)
                ins[31:27] = 5'(ops[$urandom_range(0, ops.size() - 1)]);
            step("rand", $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0, $urandom, ins);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
